cheri_regfile_mp: RTL and testbench

- Parametrised successor of the CHERI capability register file: NRPORTS read ports and NWPORTS write ports.
- Keeps the per-register load-capability reservation scoreboard (trsv/trvk) and adds a background revocation sweeper.
- The sweeper walks every valid capability register, asks an external revocation-bitmap lookup whether each is revoked, and clears its tag if so.
- Sits in the ibex CHERI core between the ID-stage operand fetch, WB writeback and the load-capability revocation path.

---
 rtl/cheri_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 tb/tb_cheri_regfile_mp.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheri_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : cheri_regfile_mp
// Description : Multi-port CHERI capability register file with load-capability
//               reservation scoreboard (trsv/trvk) and a background revocation
//               sweeper that asks an external bitmap lookup about every valid
//               capability and clears the tags of revoked ones.
// Revision    : 1.0 - initial release
// ============================================================================
module cheri_regfile_mp #(
    parameter int NREGS      = 32,
    parameter int NCAPS      = 32,
    parameter int NRPORTS    = 2,
    parameter int NWPORTS    = 2,
    parameter int DataWidth  = 32,
    parameter int CapWidth   = 38,
    parameter int TrvkBypass = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NRPORTS*5-1:0]          raddr_i,
    output logic [NRPORTS*DataWidth-1:0]  rdata_o,
    output logic [NRPORTS*CapWidth-1:0]   rcap_o,
    input  logic [NWPORTS*5-1:0]          waddr_i,
    input  logic [NWPORTS*DataWidth-1:0]  wdata_i,
    input  logic [NWPORTS*CapWidth-1:0]   wcap_i,
    input  logic [NWPORTS-1:0]            we_i,
    input  logic [4:0]                    trsv_addr_i,
    input  logic                          trsv_en_i,
    input  logic [4:0]                    trvk_addr_i,
    input  logic                          trvk_en_i,
    input  logic                          trvk_clrtag_i,
    output logic [31:0]                   reg_rdy_o,
    input  logic                          sweep_req_i,
    output logic                          sweep_busy_o,
    output logic                          sweep_done_o,
    output logic [5:0]                    sweep_nclr_o,
    output logic                          lk_valid_o,
    input  logic                          lk_ready_i,
    output logic [31:0]                   lk_data_o,
    output logic [CapWidth-1:0]           lk_cap_o,
    input  logic                          lk_rsp_valid_i,
    input  logic                          lk_revoked_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int TAG = CapWidth - 1;

    logic [DataWidth-1:0] data_q [NREGS];
    logic [DataWidth-1:0] data_d [NREGS];
    logic [CapWidth-1:0]  cap_q  [NCAPS];
    logic [CapWidth-1:0]  cap_d  [NCAPS];
    logic [31:0]          rdy_q, rdy_d;

    state_e               state_q;
    logic [5:0]           idx_q;
    logic                 dirty_q;
    logic [5:0]           nclr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 lkv_q;
    logic [31:0]          lk_data_q;
    logic [CapWidth-1:0]  lk_cap_q;

    logic [DataWidth-1:0] idx_data;
    logic [CapWidth-1:0]  idx_cap;
    logic                 wr_hit;
    logic                 trvk_hit;
    logic                 trsv_hit;
    logic                 sweep_clr;

    // ------------------------------------------------------------------
    // Combinational read ports; r0 and non-capability indices read NULL
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NRPORTS; p++) begin : g_rd
        logic [4:0]           ra;
        logic [DataWidth-1:0] rd;
        logic [CapWidth-1:0]  rc;

        // Select register contents and forward a same-cycle trvk tag clear
        always_comb begin
            ra = raddr_i[5*p +: 5];
            rd = '0;
            rc = '0;
            for (int i = 1; i < NREGS; i++) begin
                if (32'(ra) == i) rd = data_q[i];
            end
            for (int i = 1; i < NCAPS; i++) begin
                if (32'(ra) == i) rc = cap_q[i];
            end
            if (TrvkBypass != 0 && trvk_en_i && trvk_clrtag_i && trvk_addr_i == ra)
                rc[TAG] = 1'b0;
        end

        assign rdata_o[p*DataWidth +: DataWidth] = rd;
        assign rcap_o[p*CapWidth +: CapWidth]    = rc;
    end

    // Ready vector: constant-1 entries plus optional same-cycle trvk forward
    always_comb begin
        reg_rdy_o    = rdy_q;
        reg_rdy_o[0] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= NCAPS) reg_rdy_o[i] = 1'b1;
        end
        if (TrvkBypass != 0 && trvk_en_i && trvk_clrtag_i &&
            !(trsv_en_i && trsv_addr_i == trvk_addr_i))
            reg_rdy_o[trvk_addr_i] = 1'b1;
    end

    // Contents of the register currently addressed by the sweeper
    always_comb begin
        idx_data = '0;
        idx_cap  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (32'(idx_q) == i) idx_data = data_q[i];
        end
        for (int i = 0; i < NCAPS; i++) begin
            if (32'(idx_q) == i) idx_cap = cap_q[i];
        end
    end

    // Same-cycle activity on the swept register that must veto or dirty it
    always_comb begin
        wr_hit = 1'b0;
        for (int p = 0; p < NWPORTS; p++) begin
            if (we_i[p] && {1'b0, waddr_i[5*p +: 5]} == idx_q) wr_hit = 1'b1;
        end
        trvk_hit  = trvk_en_i && ({1'b0, trvk_addr_i} == idx_q);
        trsv_hit  = trsv_en_i && ({1'b0, trsv_addr_i} == idx_q);
        sweep_clr = (state_q == S_WAIT) && lk_rsp_valid_i && lk_revoked_i &&
                    !dirty_q && !wr_hit && !trvk_hit;
    end

    // Next register state: sweep clear < write ports (high index wins) < trvk clrtag
    always_comb begin
        for (int i = 0; i < NREGS; i++) data_d[i] = data_q[i];
        for (int i = 0; i < NCAPS; i++) cap_d[i] = cap_q[i];

        if (sweep_clr) begin
            for (int i = 1; i < NCAPS; i++) begin
                if (32'(idx_q) == i) cap_d[i][TAG] = 1'b0;
            end
        end

        for (int p = 0; p < NWPORTS; p++) begin
            if (we_i[p]) begin
                for (int i = 1; i < NREGS; i++) begin
                    if (32'(waddr_i[5*p +: 5]) == i)
                        data_d[i] = wdata_i[p*DataWidth +: DataWidth];
                end
                for (int i = 1; i < NCAPS; i++) begin
                    if (32'(waddr_i[5*p +: 5]) == i)
                        cap_d[i] = wcap_i[p*CapWidth +: CapWidth];
                end
            end
        end

        if (trvk_en_i && trvk_clrtag_i) begin
            for (int i = 1; i < NCAPS; i++) begin
                if (32'(trvk_addr_i) == i) cap_d[i][TAG] = 1'b0;
            end
        end

        data_d[0] = '0;
        cap_d[0]  = '0;

        rdy_d = rdy_q;
        if (trvk_en_i) rdy_d[trvk_addr_i] = 1'b1;
        if (trsv_en_i) rdy_d[trsv_addr_i] = 1'b0;
    end

    // Register file and reservation scoreboard storage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) data_q[i] <= '0;
            for (int i = 0; i < NCAPS; i++) cap_q[i] <= '0;
            rdy_q <= '1;
        end else begin
            data_q <= data_d;
            cap_q  <= cap_d;
            rdy_q  <= rdy_d;
        end
    end

    // Revocation sweeper FSM with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            dirty_q   <= 1'b0;
            nclr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lkv_q     <= 1'b0;
            lk_data_q <= '0;
            lk_cap_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sweep_req_i) begin
                        state_q <= S_SCAN;
                        idx_q   <= 6'd1;
                        nclr_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (32'(idx_q) >= NCAPS) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (!idx_cap[TAG]) begin
                        idx_q <= idx_q + 6'd1;
                    end else if (rdy_q[idx_q[4:0]]) begin
                        lk_data_q <= 32'(idx_data);
                        lk_cap_q  <= idx_cap;
                        dirty_q   <= 1'b0;
                        lkv_q     <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (wr_hit || trsv_hit) dirty_q <= 1'b1;
                    if (lk_ready_i) begin
                        lkv_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wr_hit || trsv_hit) dirty_q <= 1'b1;
                    if (lk_rsp_valid_i) begin
                        if (sweep_clr && nclr_q != 6'd63) nclr_q <= nclr_q + 6'd1;
                        idx_q   <= idx_q + 6'd1;
                        state_q <= S_SCAN;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sweep_busy_o = busy_q;
    assign sweep_done_o = done_q;
    assign sweep_nclr_o = nclr_q;
    assign lk_valid_o   = lkv_q;
    assign lk_data_o    = lk_data_q;
    assign lk_cap_o     = lk_cap_q;

endmodule
`default_nettype wire

// File: tb/tb_cheri_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_cheri_regfile_mp
// Description : Directed self-checking bench for cheri_regfile_mp with a
//               simple revocation-lookup responder folded into the step task.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cheri_regfile_mp;
    localparam int DW = 32;
    localparam int CW = 38;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [9:0]      raddr_i = '0;
    logic [2*DW-1:0] rdata_o;
    logic [2*CW-1:0] rcap_o;
    logic [9:0]      waddr_i = '0;
    logic [2*DW-1:0] wdata_i = '0;
    logic [2*CW-1:0] wcap_i = '0;
    logic [1:0]      we_i = '0;
    logic [4:0]      trsv_addr_i = '0;
    logic            trsv_en_i = 1'b0;
    logic [4:0]      trvk_addr_i = '0;
    logic            trvk_en_i = 1'b0;
    logic            trvk_clrtag_i = 1'b0;
    logic [31:0]     reg_rdy_o;
    logic            sweep_req_i = 1'b0;
    logic            sweep_busy_o;
    logic            sweep_done_o;
    logic [5:0]      sweep_nclr_o;
    logic            lk_valid_o;
    logic            lk_ready_i = 1'b1;
    logic [31:0]     lk_data_o;
    logic [CW-1:0]   lk_cap_o;
    logic            lk_rsp_valid_i = 1'b0;
    logic            lk_revoked_i = 1'b0;

    cheri_regfile_mp dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .rcap_o         (rcap_o),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .wcap_i         (wcap_i),
        .we_i           (we_i),
        .trsv_addr_i    (trsv_addr_i),
        .trsv_en_i      (trsv_en_i),
        .trvk_addr_i    (trvk_addr_i),
        .trvk_en_i      (trvk_en_i),
        .trvk_clrtag_i  (trvk_clrtag_i),
        .reg_rdy_o      (reg_rdy_o),
        .sweep_req_i    (sweep_req_i),
        .sweep_busy_o   (sweep_busy_o),
        .sweep_done_o   (sweep_done_o),
        .sweep_nclr_o   (sweep_nclr_o),
        .lk_valid_o     (lk_valid_o),
        .lk_ready_i     (lk_ready_i),
        .lk_data_o      (lk_data_o),
        .lk_cap_o       (lk_cap_o),
        .lk_rsp_valid_i (lk_rsp_valid_i),
        .lk_revoked_i   (lk_revoked_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // responder / monitor state
    int          rsp_lat = 1;
    int          rsp_cnt = 0;
    int          ready_hold = 0;
    logic [31:0] revoke_data = 32'hFFFF_FFFF;
    logic [31:0] pend_data = '0;
    int          lookups = 0;
    logic [31:0] lk_log [8];
    int          done_cnt = 0;
    bit          last_hs = 1'b0;

    localparam logic [CW-1:0] C3  = {1'b1, 37'h33};
    localparam logic [CW-1:0] C4  = {1'b1, 37'h44};
    localparam logic [CW-1:0] C7  = {1'b1, 37'h05};
    localparam logic [CW-1:0] C9  = {1'b1, 37'h99};
    localparam logic [CW-1:0] C3N = {1'b1, 37'h1234};

    // One clock; afterwards drives the lookup responder and counts events
    task automatic step();
        bit          hs;
        logic [31:0] hd;
        hs = lk_valid_o && lk_ready_i;
        hd = lk_data_o;
        @(posedge clk);
        #1;
        last_hs = hs;
        if (hs) begin
            if (lookups < 8) lk_log[lookups] = hd;
            lookups++;
            pend_data = hd;
            rsp_cnt = rsp_lat;
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
        end
        lk_rsp_valid_i = (rsp_cnt == 1);
        lk_revoked_i   = (rsp_cnt == 1) && (pend_data == revoke_data);
        if (lk_valid_o && ready_hold > 0) begin
            lk_ready_i = 1'b0;
            ready_hold--;
        end else begin
            lk_ready_i = 1'b1;
        end
        if (sweep_done_o) done_cnt++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        rsp_cnt = 0; ready_hold = 0; lookups = 0; done_cnt = 0;
        lk_rsp_valid_i = 1'b0; lk_revoked_i = 1'b0; lk_ready_i = 1'b1;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d,
                          input logic [CW-1:0] c);
        we_i[p]              = 1'b1;
        waddr_i[5*p +: 5]    = a;
        wdata_i[DW*p +: DW]  = d;
        wcap_i[CW*p +: CW]   = c;
    endtask

    task automatic rd(input logic [4:0] a);
        raddr_i[4:0] = a;
        #1;
    endtask

    task automatic start_sweep();
        sweep_req_i = 1'b1;
        step();
        sweep_req_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 300 && done_cnt == 0; k++) step();
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done: sweep_done_o never pulsed, done count %0d required 1", nm, done_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        rd(5'd5);
        checks++; if (reg_rdy_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_rdy: got %h exp ffffffff", reg_rdy_o); end
        checks++; if (sweep_busy_o !== 1'b0 || sweep_done_o !== 1'b0 || lk_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_ctl: busy %b done %b lkv %b exp 0 0 0", sweep_busy_o, sweep_done_o, lk_valid_o); end
        checks++; if (sweep_nclr_o !== 6'd0) begin errors++; $display("FAIL rst_nclr: got %0d exp 0", sweep_nclr_o); end
        checks++; if (rdata_o[31:0] !== 32'd0 || rcap_o[CW-1:0] !== '0) begin
            errors++; $display("FAIL rst_r5: data %h cap %h exp 0 0", rdata_o[31:0], rcap_o[CW-1:0]); end
    endtask

    task automatic test_write_collision();
        set_wr(0, 5'd5, 32'h11, '0);
        set_wr(1, 5'd5, 32'h22, '0);
        rd(5'd5);
        checks++; if (rdata_o[31:0] !== 32'd0) begin errors++; $display("FAIL no_bypass: got %h exp 0", rdata_o[31:0]); end
        step();
        we_i = '0;
        rd(5'd5);
        checks++; if (rdata_o[31:0] !== 32'h22) begin errors++; $display("FAIL collide_r5: got %h exp 22", rdata_o[31:0]); end
        set_wr(0, 5'd0, 32'hDEAD, C3);
        step();
        we_i = '0;
        rd(5'd0);
        checks++; if (rdata_o[31:0] !== 32'd0 || rcap_o[CW-1:0] !== '0) begin
            errors++; $display("FAIL r0_write: data %h cap %h exp 0 0", rdata_o[31:0], rcap_o[CW-1:0]); end
    endtask

    task automatic test_trsv_trvk();
        set_wr(0, 5'd7, 32'h77, C7);
        step();
        we_i = '0;
        trsv_en_i = 1'b1; trsv_addr_i = 5'd7;
        step();
        trsv_en_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (reg_rdy_o[7] !== 1'b0) begin errors++; $display("FAIL rsv_cycle%0d: rdy7 %b exp 0", k, reg_rdy_o[7]); end
            step();
        end
        trvk_en_i = 1'b1; trvk_clrtag_i = 1'b1; trvk_addr_i = 5'd7;
        rd(5'd7);
        checks++; if (reg_rdy_o[7] !== 1'b1 || rcap_o[CW-1] !== 1'b0) begin
            errors++; $display("FAIL trvk_bypass: rdy7 %b tag %b exp 1 0", reg_rdy_o[7], rcap_o[CW-1]); end
        step();
        trvk_en_i = 1'b0; trvk_clrtag_i = 1'b0;
        rd(5'd7);
        checks++; if (rcap_o[CW-1:0] !== {1'b0, 37'h05} || rdata_o[31:0] !== 32'h77 || reg_rdy_o[7] !== 1'b1) begin
            errors++; $display("FAIL trvk_commit: cap %h data %h rdy %b exp %h 77 1", rcap_o[CW-1:0], rdata_o[31:0], reg_rdy_o[7], {1'b0, 37'h05}); end
    endtask

    task automatic test_sweep_revoke();
        do_reset();
        set_wr(0, 5'd3, 32'h300, C3);
        set_wr(1, 5'd9, 32'h900, C9);
        step();
        we_i = '0;
        revoke_data = 32'h900; rsp_lat = 1;
        start_sweep();
        checks++; if (sweep_busy_o !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b exp 1", sweep_busy_o); end
        wait_done("sw");
        checks++; if (lookups != 2 || lk_log[0] !== 32'h300 || lk_log[1] !== 32'h900) begin
            errors++; $display("FAIL sw_lookups: n %0d first %h second %h exp 2 300 900", lookups, lk_log[0], lk_log[1]); end
        checks++; if (sweep_nclr_o !== 6'd1) begin errors++; $display("FAIL sw_nclr: got %0d exp 1", sweep_nclr_o); end
        step();
        checks++; if (sweep_busy_o !== 1'b0 || sweep_done_o !== 1'b0) begin
            errors++; $display("FAIL sw_idle: busy %b done %b exp 0 0", sweep_busy_o, sweep_done_o); end
        step(); step(); step();
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL sw_done_once: got %0d exp 1", done_cnt); end
        rd(5'd9);
        checks++; if (rcap_o[CW-1:0] !== {1'b0, 37'h99} || rdata_o[31:0] !== 32'h900) begin
            errors++; $display("FAIL sw_r9: cap %h data %h exp %h 900", rcap_o[CW-1:0], rdata_o[31:0], {1'b0, 37'h99}); end
        rd(5'd3);
        checks++; if (rcap_o[CW-1:0] !== C3) begin errors++; $display("FAIL sw_r3: cap %h exp %h", rcap_o[CW-1:0], C3); end
    endtask

    task automatic test_dirty();
        do_reset();
        set_wr(0, 5'd3, 32'h300, C3);
        step();
        we_i = '0;
        revoke_data = 32'h300; rsp_lat = 2;
        start_sweep();
        for (int k = 0; k < 60 && !last_hs; k++) step();
        checks++; if (!last_hs) begin errors++; $display("FAIL dirty_hs: lookup handshake not seen, got 0 exp 1"); end
        set_wr(0, 5'd3, 32'h301, C3N);
        step();
        we_i = '0;
        wait_done("dirty");
        checks++; if (sweep_nclr_o !== 6'd0 || lookups != 1) begin
            errors++; $display("FAIL dirty_nclr: nclr %0d lookups %0d exp 0 1", sweep_nclr_o, lookups); end
        rd(5'd3);
        checks++; if (rcap_o[CW-1:0] !== C3N || rdata_o[31:0] !== 32'h301) begin
            errors++; $display("FAIL dirty_r3: cap %h data %h exp %h 301", rcap_o[CW-1:0], rdata_o[31:0], C3N); end
    endtask

    task automatic test_stall();
        int bad;
        int vcnt;
        int unstable;
        logic [CW-1:0] cap0;
        do_reset();
        set_wr(1, 5'd4, 32'h400, C4);
        step();
        we_i = '0;
        trsv_en_i = 1'b1; trsv_addr_i = 5'd4;
        step();
        trsv_en_i = 1'b0;
        revoke_data = 32'hFFFF_FFFF; rsp_lat = 1; ready_hold = 5;
        start_sweep();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (lk_valid_o) bad++;
            step();
        end
        checks++; if (bad != 0 || sweep_busy_o !== 1'b1 || reg_rdy_o[4] !== 1'b0) begin
            errors++; $display("FAIL stall: valid cycles %0d busy %b rdy4 %b exp 0 1 0", bad, sweep_busy_o, reg_rdy_o[4]); end
        trvk_en_i = 1'b1; trvk_addr_i = 5'd4; trvk_clrtag_i = 1'b0;
        step();
        trvk_en_i = 1'b0;
        for (int k = 0; k < 10 && !lk_valid_o; k++) step();
        checks++; if (lk_valid_o !== 1'b1) begin errors++; $display("FAIL stall_issue: lk_valid %b exp 1", lk_valid_o); end
        cap0 = lk_cap_o;
        vcnt = 0; unstable = 0;
        while (lk_valid_o && vcnt < 20) begin
            vcnt++;
            if (lk_cap_o !== cap0 || lk_data_o !== 32'h400) unstable++;
            step();
        end
        checks++; if (cap0 !== C4 || unstable != 0 || vcnt != 6) begin
            errors++; $display("FAIL hold_stable: cap %h unstable %0d valid cycles %0d exp %h 0 6", cap0, unstable, vcnt, C4); end
        wait_done("stall");
        rd(5'd4);
        checks++; if (sweep_nclr_o !== 6'd0 || rcap_o[CW-1:0] !== C4 || lookups != 1) begin
            errors++; $display("FAIL stall_end: nclr %0d cap %h lookups %0d exp 0 %h 1", sweep_nclr_o, rcap_o[CW-1:0], lookups, C4); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_wr(0, 5'd3, 32'h300, C3);
        step();
        we_i = '0;
        revoke_data = 32'h300; rsp_lat = 3;
        start_sweep();
        for (int k = 0; k < 60 && !last_hs; k++) step();
        checks++; if (!last_hs || sweep_busy_o !== 1'b1) begin
            errors++; $display("FAIL mid_wait: hs %b busy %b exp 1 1", last_hs, sweep_busy_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        rd(5'd3);
        checks++; if (sweep_busy_o !== 1'b0 || sweep_nclr_o !== 6'd0 || lk_valid_o !== 1'b0 || sweep_done_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctl: busy %b nclr %0d lkv %b done %b exp 0 0 0 0", sweep_busy_o, sweep_nclr_o, lk_valid_o, sweep_done_o); end
        checks++; if (rcap_o[CW-1:0] !== '0 || rdata_o[31:0] !== 32'd0) begin
            errors++; $display("FAIL mid_rst_r3: cap %h data %h exp 0 0", rcap_o[CW-1:0], rdata_o[31:0]); end
        for (int k = 0; k < 6; k++) step();
        checks++; if (done_cnt != 0 || sweep_busy_o !== 1'b0) begin
            errors++; $display("FAIL mid_no_done: done count %0d busy %b exp 0 0", done_cnt, sweep_busy_o); end
    endtask

    initial begin
        test_reset();
        test_write_collision();
        test_trsv_trvk();
        test_sweep_revoke();
        test_dirty();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
